rtc_tick_cascade: RTL and testbench

// - Parametrised base-tick generator plus cascaded decade dividers for the stopwatch timebase.
// - Divides i_sclk to a base tick, then chains N_STAGES divide-by-STAGE_DIV stages.

---
 rtl/rtc_tick_cascade_pkg.sv | 27 ++
 rtl/rtc_tick_cascade_if.sv | 31 +++
 rtl/rtc_tick_cascade_mod_counter.sv | 42 ++++
 rtl/rtc_tick_cascade.sv | 106 ++++++++++
 tb/tb_rtc_tick_cascade.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rtc_tick_cascade_pkg.sv
// Shared constants, types and helpers for the stopwatch timebase.
package rtc_pkg;

    // Ceiling log2, never less than 1 so that every counter has at least one bit.
    function automatic int clog2(input longint unsigned value);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    localparam int RTC_CLK_HZ    = 100_000_000;
    localparam int RTC_BASE_HZ   = 100;
    localparam int RTC_STAGE_DIV = 10;
    localparam int RTC_N_STAGES  = 3;
    localparam int RTC_SW        = clog2(RTC_STAGE_DIV);

    typedef logic [RTC_SW-1:0] stage_cnt_t;

endpackage

// File: rtl/rtc_tick_cascade_if.sv
// Control/status bundle between the stopwatch logic and the timebase.
interface rtc_tick_cascade_if
    import rtc_pkg::*;
#(
    parameter int N_STAGES = RTC_N_STAGES,
    parameter int SW       = RTC_SW
);
    logic                     i_timerenb;
    logic                     i_clear;
    logic [N_STAGES:0]        o_tick;
    logic [N_STAGES:0]        o_level;
    logic [N_STAGES*SW-1:0]   o_stage_cnt;

    // Consumer side: drives enable/clear, observes ticks.
    modport master (
        output i_timerenb,
        output i_clear,
        input  o_tick,
        input  o_level,
        input  o_stage_cnt
    );

    // Timebase side.
    modport slave (
        input  i_timerenb,
        input  i_clear,
        output o_tick,
        output o_level,
        output o_stage_cnt
    );
endinterface

// File: rtl/rtc_tick_cascade_mod_counter.sv
// Modulo-MOD counter with synchronous clear and a combinational wrap flag.
module rtc_mod_counter
    import rtc_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic                  i_sclk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [clog2(MOD)-1:0] o_cnt,
    output logic                  o_wrap
);
    localparam int W = clog2(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap is asserted on the increment that takes the count from LAST back to 0.
    assign o_wrap = i_inc && (cnt_q == LAST);
    assign o_cnt  = cnt_q;

    // Next count: clear beats increment; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rtc_tick_cascade.sv
// Base-tick prescaler followed by a cascade of decade dividers. Every stage
// increments on the combinational wrap of the previous one, so the strobes of a
// full cascade wrap land on the same edge and the counts move with their tick.
module rtc_tick_cascade
    import rtc_pkg::*;
#(
    parameter int CLK_HZ    = RTC_CLK_HZ,
    parameter int BASE_HZ   = RTC_BASE_HZ,
    parameter int N_STAGES  = RTC_N_STAGES,
    parameter int STAGE_DIV = RTC_STAGE_DIV
) (
    input  logic               i_sclk,
    input  logic               i_reset,
    rtc_tick_cascade_if.slave  bus
);
    localparam int PRESCALE = CLK_HZ / BASE_HZ;
    localparam int PW       = clog2(PRESCALE);
    localparam int SW       = clog2(STAGE_DIV);

    if (BASE_HZ <= 0 || (CLK_HZ % BASE_HZ) != 0) begin : g_bad_ratio
        $fatal(1, "rtc_tick_cascade: CLK_HZ must be an integer multiple of BASE_HZ");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $fatal(1, "rtc_tick_cascade: PRESCALE must be at least 2");
    end
    if (STAGE_DIV < 2) begin : g_bad_div
        $fatal(1, "rtc_tick_cascade: STAGE_DIV must be at least 2");
    end
    if (N_STAGES < 1) begin : g_bad_stages
        $fatal(1, "rtc_tick_cascade: N_STAGES must be at least 1");
    end

    logic                   en;
    logic                   clr;
    logic [N_STAGES:0]      wrap;
    logic [PW-1:0]          pcnt;
    logic [SW-1:0]          scnt [N_STAGES];
    logic [N_STAGES*SW-1:0] stage_cnt_packed;

    logic [N_STAGES:0]      tick_q;
    logic [N_STAGES:0]      tick_d;
    logic [N_STAGES:0]      level_q;
    logic [N_STAGES:0]      level_d;

    assign en  = bus.i_timerenb;
    assign clr = bus.i_clear;

    rtc_mod_counter #(.MOD(PRESCALE)) u_prescale (
        .i_sclk  (i_sclk),
        .i_reset (i_reset),
        .i_clear (clr),
        .i_inc   (en),
        .o_cnt   (pcnt),
        .o_wrap  (wrap[0])
    );

    for (genvar k = 1; k <= N_STAGES; k++) begin : g_stage
        rtc_mod_counter #(.MOD(STAGE_DIV)) u_stage (
            .i_sclk  (i_sclk),
            .i_reset (i_reset),
            .i_clear (clr),
            .i_inc   (wrap[k-1]),
            .o_cnt   (scnt[k-1]),
            .o_wrap  (wrap[k])
        );
        assign stage_cnt_packed[(k-1)*SW +: SW] = scnt[k-1];

        a_scnt_range: assert property (@(posedge i_sclk) disable iff (i_reset)
            int'(scnt[k-1]) < STAGE_DIV);
    end

    for (genvar k = 0; k <= N_STAGES; k++) begin : g_tick_chk
        a_tick_single: assert property (@(posedge i_sclk) disable iff (i_reset)
            tick_q[k] |=> !tick_q[k]);
    end

    a_pcnt_range: assert property (@(posedge i_sclk) disable iff (i_reset)
        int'(pcnt) < PRESCALE);

    // Strobe and level next-state: a clear discards any coincident wrap.
    always_comb begin
        tick_d  = '0;
        level_d = level_q;
        if (clr) begin
            level_d = '0;
        end else if (en) begin
            tick_d  = wrap;
            level_d = level_q ^ wrap;
        end
    end

    // Strobe and level registers.
    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            tick_q  <= '0;
            level_q <= '0;
        end else begin
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign bus.o_tick      = tick_q;
    assign bus.o_level     = level_q;
    assign bus.o_stage_cnt = stage_cnt_packed;
endmodule

// File: tb/tb_rtc_tick_cascade.sv
// Directed bench for rtc_tick_cascade with PRESCALE=10, two decade stages.
module tb_rtc_tick_cascade;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;   // enabled cycles since the last phase restart

    always #5 clk = ~clk;

    rtc_tick_cascade_if #(.N_STAGES(2), .SW(4)) bus ();

    rtc_tick_cascade #(
        .CLK_HZ    (1000),
        .BASE_HZ   (100),
        .N_STAGES  (2),
        .STAGE_DIV (10)
    ) dut (
        .i_sclk  (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model, a pure function of the enabled-cycle count.
    function automatic logic [2:0] exp_tick(input int cyc, input bit fired);
        if (!fired || cyc == 0) return 3'b000;
        return {cyc % 1000 == 0, cyc % 100 == 0, cyc % 10 == 0};
    endfunction

    function automatic logic [2:0] exp_level(input int cyc);
        return {((cyc / 1000) % 2) == 1, ((cyc / 100) % 2) == 1, ((cyc / 10) % 2) == 1};
    endfunction

    function automatic logic [7:0] exp_cnt(input int cyc);
        return {4'((cyc / 100) % 10), 4'((cyc / 10) % 10)};
    endfunction

    // Advance one clock, sample 1 time unit after the edge, track the model count.
    task automatic adv();
        bit counted;
        counted = bus.i_timerenb && !bus.i_clear && !rst;
        @(posedge clk);
        #1;
        if (counted) n++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_timerenb = 1'b0;
        bus.i_clear = 1'b0;
        for (int i = 0; i < 3; i++) adv();
        checks++;
        if (bus.o_tick !== 3'b000) begin
            errors++; $display("FAIL reset_tick got %b want 000", bus.o_tick);
        end
        checks++;
        if (bus.o_level !== 3'b000) begin
            errors++; $display("FAIL reset_level got %b want 000", bus.o_level);
        end
        checks++;
        if (bus.o_stage_cnt !== 8'h00) begin
            errors++; $display("FAIL reset_cnt got %h want 00", bus.o_stage_cnt);
        end
        rst = 1'b0;
        bus.i_timerenb = 1'b1;
        n = 0;
    endtask

    task automatic test_base_tick();
        for (int i = 0; i < 30; i++) begin
            adv();
            checks++;
            if (bus.o_tick !== exp_tick(n, 1'b1)) begin
                errors++; $display("FAIL base_tick cyc %0d got %b want %b", n, bus.o_tick, exp_tick(n, 1'b1));
            end
            checks++;
            if (bus.o_level !== exp_level(n)) begin
                errors++; $display("FAIL base_level cyc %0d got %b want %b", n, bus.o_level, exp_level(n));
            end
        end
    endtask

    task automatic test_cascade();
        while (n < 1000) begin
            adv();
            checks++;
            if (bus.o_tick !== exp_tick(n, 1'b1)) begin
                errors++; $display("FAIL cascade_tick cyc %0d got %b want %b", n, bus.o_tick, exp_tick(n, 1'b1));
            end
            checks++;
            if (bus.o_stage_cnt !== exp_cnt(n)) begin
                errors++; $display("FAIL cascade_cnt cyc %0d got %h want %h", n, bus.o_stage_cnt, exp_cnt(n));
            end
            checks++;
            if (bus.o_level !== exp_level(n)) begin
                errors++; $display("FAIL cascade_level cyc %0d got %b want %b", n, bus.o_level, exp_level(n));
            end
        end
        checks++;
        if (bus.o_tick !== 3'b111) begin
            errors++; $display("FAIL full_wrap_tick got %b want 111", bus.o_tick);
        end
        checks++;
        if (bus.o_stage_cnt !== 8'h00) begin
            errors++; $display("FAIL full_wrap_cnt got %h want 00", bus.o_stage_cnt);
        end
    endtask

    task automatic test_freeze();
        logic [2:0] lvl_before;
        int wait_cyc;
        for (int i = 0; i < 4; i++) adv();   // prescaler now at 4
        lvl_before = bus.o_level;
        bus.i_timerenb = 1'b0;
        for (int i = 0; i < 37; i++) begin
            adv();
            checks++;
            if (bus.o_tick !== 3'b000) begin
                errors++; $display("FAIL freeze_tick step %0d got %b want 000", i, bus.o_tick);
            end
            checks++;
            if (bus.o_level !== lvl_before || bus.o_stage_cnt !== exp_cnt(n)) begin
                errors++; $display("FAIL freeze_hold step %0d got lvl %b cnt %h want lvl %b cnt %h",
                                   i, bus.o_level, bus.o_stage_cnt, lvl_before, exp_cnt(n));
            end
        end
        bus.i_timerenb = 1'b1;
        wait_cyc = 0;
        do begin
            adv();
            wait_cyc++;
            checks++;
            if (bus.o_tick !== exp_tick(n, 1'b1)) begin
                errors++; $display("FAIL resume_tick cyc %0d got %b want %b", n, bus.o_tick, exp_tick(n, 1'b1));
            end
        end while (bus.o_tick[0] !== 1'b1 && wait_cyc < 20);
        checks++;
        if (wait_cyc !== 6) begin
            errors++; $display("FAIL resume_latency got %0d want 6", wait_cyc);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 9; i++) adv();   // prescaler now at 9
        bus.i_clear = 1'b1;
        adv();
        n = 0;
        checks++;
        if (bus.o_tick !== 3'b000) begin
            errors++; $display("FAIL clear_tick got %b want 000", bus.o_tick);
        end
        checks++;
        if (bus.o_level !== 3'b000 || bus.o_stage_cnt !== 8'h00) begin
            errors++; $display("FAIL clear_state got lvl %b cnt %h want lvl 000 cnt 00",
                               bus.o_level, bus.o_stage_cnt);
        end
        bus.i_clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adv();
            checks++;
            if (bus.o_tick !== exp_tick(n, 1'b1)) begin
                errors++; $display("FAIL post_clear_tick cyc %0d got %b want %b", n, bus.o_tick, exp_tick(n, 1'b1));
            end
        end
    endtask

    task automatic test_reset_mid();
        while (n < 735) begin
            adv();
            checks++;
            if (bus.o_stage_cnt !== exp_cnt(n) || bus.o_tick !== exp_tick(n, 1'b1)) begin
                errors++; $display("FAIL pre_reset cyc %0d got cnt %h tick %b want cnt %h tick %b",
                                   n, bus.o_stage_cnt, bus.o_tick, exp_cnt(n), exp_tick(n, 1'b1));
            end
        end
        checks++;
        if (bus.o_stage_cnt !== 8'h73) begin
            errors++; $display("FAIL mid_cnt got %h want 73", bus.o_stage_cnt);
        end
        rst = 1'b1;
        adv();
        rst = 1'b0;
        n = 0;
        checks++;
        if (bus.o_tick !== 3'b000 || bus.o_level !== 3'b000 || bus.o_stage_cnt !== 8'h00) begin
            errors++; $display("FAIL mid_reset got tick %b lvl %b cnt %h want all zero",
                               bus.o_tick, bus.o_level, bus.o_stage_cnt);
        end
        for (int i = 0; i < 30; i++) begin
            adv();
            checks++;
            if (bus.o_tick !== exp_tick(n, 1'b1) || bus.o_level !== exp_level(n)) begin
                errors++; $display("FAIL restart cyc %0d got tick %b lvl %b want tick %b lvl %b",
                                   n, bus.o_tick, bus.o_level, exp_tick(n, 1'b1), exp_level(n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_base_tick();
        test_cascade();
        test_freeze();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
